tt_rng_arbiter: RTL and testbench

//  Shares one 16-bit Fibonacci LFSR (x^16+x^15+x^13+x^4+1) among NUM_REQ requesters.

---
 rtl/tt_rng_pkg.sv | 19 +
 rtl/tt_rng_lfsr16.sv | 27 ++
 rtl/tt_rng_arbiter.sv | 141 ++++++++++++++
 tb/tb_tt_rng_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_rng_pkg.sv
// Shared types and constants for the tt_rng_arbiter random-word server.
package tt_rng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam int          LFSR_W     = 16;
  // Taps for x^16+x^15+x^13+x^4+1 on a left-shifting register: bits 15,14,12,3.
  localparam logic [15:0] LFSR_TAPS  = 16'hD008;
  localparam logic [15:0] LFSR_RESET = 16'h0001;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/tt_rng_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR with step/load controls and an all-zero seed guard.
module tt_rng_lfsr16
  import tt_rng_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] state,
  output logic        fb
);

  assign fb = lfsr_feedback(state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_RESET;
    end else if (load) begin
      // All-zero is the lock-up state of an XOR LFSR, so never let it in.
      state <= (load_val == 16'h0000) ? LFSR_RESET : load_val;
    end else if (step) begin
      state <= {state[14:0], fb};
    end
  end

endmodule

// File: rtl/tt_rng_arbiter.sv
// Round-robin server handing out WORD_W-bit words from one shared LFSR to NUM_REQ requesters.
// Optional macro TT_RNG_WHITEN_EN: XOR each collected bit with LFSR bit 7 (sequence unchanged).
module tt_rng_arbiter
  import tt_rng_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [15:0]        seed_data,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               rnd_valid,
  output logic [WORD_W-1:0]  rnd_data,
  output logic [ID_W-1:0]    rnd_id,
  output logic               busy
);

  localparam int CNT_W = $clog2(WORD_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  state_t              fsm_state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     gnt_id;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   shift_reg;
  logic [WORD_W-1:0]   shift_next;
  logic [15:0]         lfsr_state;
  logic                lfsr_fb;
  logic                lfsr_step;
  logic                collect_bit;
  logic                gnt_req;
  logic [ID_W-1:0]     rr_next;
  logic                pick_found;
  logic [ID_W-1:0]     pick_id;

  tt_rng_lfsr16 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (lfsr_step),
    .load     (seed_load),
    .load_val (seed_data),
    .state    (lfsr_state),
    .fb       (lfsr_fb)
  );

`ifdef TT_RNG_WHITEN_EN
  assign collect_bit = lfsr_fb ^ lfsr_state[7];
`else
  assign collect_bit = lfsr_fb;
`endif

  assign gnt_req   = req[gnt_id];
  // A seed load takes the place of the step in the same cycle.
  assign lfsr_step = (fsm_state == COLLECT) && gnt_req && !seed_load;
  assign rr_next   = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;

  generate
    if (WORD_W > 1) begin : g_shift_wide
      assign shift_next = {shift_reg[WORD_W-2:0], collect_bit};
    end else begin : g_shift_one
      assign shift_next = collect_bit;
    end
  endgenerate

  // Search starts at rr_ptr and wraps, so the most recently served id goes last.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [ID_W:0] idx;
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!pick_found && req[idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      grant     <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      rnd_id    <= '0;
      busy      <= 1'b0;
    end else begin
      rnd_valid <= 1'b0;
      case (fsm_state)
        IDLE: begin
          if (pick_found) begin
            grant     <= NUM_REQ'(1) << pick_id;
            gnt_id    <= pick_id;
            bit_cnt   <= '0;
            shift_reg <= '0;
            busy      <= 1'b1;
            fsm_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (!gnt_req) begin
            grant     <= '0;
            rr_ptr    <= rr_next;
            busy      <= 1'b0;
            fsm_state <= IDLE;
          end else if (seed_load) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_LAST) begin
              rnd_valid <= 1'b1;
              rnd_data  <= shift_next;
              rnd_id    <= gnt_id;
              fsm_state <= DELIVER;
            end
          end
        end
        DELIVER: begin
          grant     <= '0;
          rr_ptr    <= rr_next;
          busy      <= 1'b0;
          fsm_state <= IDLE;
        end
        default: fsm_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_rng_arbiter.sv
// Directed bench for tt_rng_arbiter (NUM_REQ=4, WORD_W=8, whitening off).
module tb_tt_rng_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seed_load = 1'b0;
  logic [15:0] seed_data = 16'h0000;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       rnd_valid;
  logic [7:0] rnd_data;
  logic [1:0] rnd_id;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  tt_rng_arbiter #(.NUM_REQ(4), .WORD_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .req       (req),
    .grant     (grant),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .rnd_id    (rnd_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns number of cycles until rnd_valid is seen, capped at 40.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (rnd_valid !== 1'b1 && lat < 40);
    $display("word id=%0d data=%h latency=%0d", rnd_id, rnd_data, lat);
  endtask

  task automatic do_reset();
    req = 4'b0000;
    seed_load = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    vectors++; if (rnd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", rnd_valid); end
    vectors++; if (rnd_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", rnd_data); end
    vectors++; if (rnd_id !== 2'd0) begin miscompares++; $display("FAIL reset_id: got %0d expected 0", rnd_id); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (dut.u_lfsr.state !== 16'h0001) begin miscompares++; $display("FAIL reset_lfsr: got %h expected 0001", dut.u_lfsr.state); end
  endtask

  task automatic test_single_word();
    int lat;
    logic [7:0] held;
    do_reset();
    req = 4'b0001;
    tick();
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL single_grant: got %b expected 0001", grant); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_valid(lat);
    vectors++; if (lat !== 8) begin miscompares++; $display("FAIL single_latency: got %0d expected 8", lat); end
    vectors++; if (rnd_data !== 8'h11) begin miscompares++; $display("FAIL single_data: got %h expected 11", rnd_data); end
    vectors++; if (rnd_id !== 2'd0) begin miscompares++; $display("FAIL single_id: got %0d expected 0", rnd_id); end
    held = rnd_data;
    req = 4'b0000;
    tick();
    tick();
    vectors++; if (rnd_valid !== 1'b0) begin miscompares++; $display("FAIL single_pulse: got %b expected 0", rnd_valid); end
    vectors++; if (rnd_data !== 8'h11) begin miscompares++; $display("FAIL single_hold: got %h expected 11 (was %h)", rnd_data, held); end
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL single_grant_clear: got %b expected 0000", grant); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_reset();
    req = 4'b0001;
    tick();
    wait_valid(lat);
    tick();
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL b2b_idle_grant: got %b expected 0000", grant); end
    tick();
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL b2b_regrant: got %b expected 0001", grant); end
    wait_valid(lat);
    vectors++; if (lat !== 8) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    vectors++; if (rnd_data !== 8'h1A) begin miscompares++; $display("FAIL b2b_data: got %h expected 1a", rnd_data); end
    vectors++; if (rnd_id !== 2'd0) begin miscompares++; $display("FAIL b2b_id: got %0d expected 0", rnd_id); end
    vectors++; if (dut.u_lfsr.state !== 16'h111A) begin miscompares++; $display("FAIL b2b_lfsr: got %h expected 111a", dut.u_lfsr.state); end
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    int lat;
    logic [1:0] exp_id [3] = '{2'd1, 2'd3, 2'd1};
    logic [3:0] exp_gnt;
    do_reset();
    req = 4'b1010;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_gnt = 4'b0001 << exp_id[k];
      vectors++; if (grant !== exp_gnt) begin miscompares++; $display("FAIL rr_grant%0d: got %b expected %b", k, grant, exp_gnt); end
      wait_valid(lat);
      vectors++; if (rnd_id !== exp_id[k]) begin miscompares++; $display("FAIL rr_id%0d: got %0d expected %0d", k, rnd_id, exp_id[k]); end
      vectors++; if (lat !== 8) begin miscompares++; $display("FAIL rr_latency%0d: got %0d expected 8", k, lat); end
      tick();
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_zero_seed();
    int lat;
    do_reset();
    req = 4'b0001;
    tick();
    wait_valid(lat);
    req = 4'b0000;
    tick();
    tick();
    seed_load = 1'b1;
    seed_data = 16'h0000;
    tick();
    seed_load = 1'b0;
    vectors++; if (dut.u_lfsr.state !== 16'h0001) begin miscompares++; $display("FAIL seed_guard: got %h expected 0001", dut.u_lfsr.state); end
    req = 4'b0100;
    tick();
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL seed_grant: got %b expected 0100", grant); end
    wait_valid(lat);
    vectors++; if (rnd_data !== 8'h11) begin miscompares++; $display("FAIL seed_data: got %h expected 11", rnd_data); end
    vectors++; if (rnd_id !== 2'd2) begin miscompares++; $display("FAIL seed_id: got %0d expected 2", rnd_id); end
    req = 4'b0000;
  endtask

  task automatic test_abort();
    int lat;
    do_reset();
    req = 4'b0110;
    tick();
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL abort_first_grant: got %b expected 0010", grant); end
    tick();
    tick();
    tick();
    req = 4'b0100;
    tick();
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL abort_grant_clear: got %b expected 0000", grant); end
    vectors++; if (rnd_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_valid: got %b expected 0", rnd_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    tick();
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL abort_next_grant: got %b expected 0100", grant); end
    wait_valid(lat);
    vectors++; if (lat !== 8) begin miscompares++; $display("FAIL abort_latency: got %0d expected 8", lat); end
    vectors++; if (rnd_id !== 2'd2) begin miscompares++; $display("FAIL abort_id: got %0d expected 2", rnd_id); end
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    int lat;
    do_reset();
    req = 4'b0001;
    tick();
    wait_valid(lat);
    tick();
    tick();
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL areset_grant: got %b expected 0000", grant); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b expected 0", busy); end
    vectors++; if (rnd_data !== 8'h00) begin miscompares++; $display("FAIL areset_data: got %h expected 00", rnd_data); end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL areset_regrant: got %b expected 0001", grant); end
    wait_valid(lat);
    vectors++; if (rnd_data !== 8'h11) begin miscompares++; $display("FAIL areset_word: got %h expected 11", rnd_data); end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_round_robin();
    test_zero_seed();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
